// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, state type and S-box helper
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int KEY_W = 128;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
endpackage

// File: rtl/aes_key_round.sv
// aes_key_round: one combinational AES-128 key-expansion step
module aes_key_round
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] rk_prev,
  input  logic [3:0]       round,
  output logic [KEY_W-1:0] rk_next
);
  logic [WORD_W-1:0] w0, w1, w2, w3, t, n0, n1, n2;
  logic [7:0] rc;
  assign {w0, w1, w2, w3} = rk_prev;
  assign rc = (round < 4'(AES_NR)) ? RCON[round] : 8'h00;
  assign t = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign rk_next = {n0, n1, n2, w3 ^ n2};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key schedule with 11-entry round-key store
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter bit REG_RD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             invalidate,
  output logic             busy,
  output logic             keys_valid,
  output logic             done,
  input  logic [3:0]       rk_rd_idx,
  output logic [KEY_W-1:0] rk_rd_data
);
  if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
    $error("aes_key_sched_ctrl supports only NUM_ROUNDS = 10");
  end
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [KEY_W-1:0] rk [AES_NR+1];
  logic [KEY_W-1:0] rk_nx, rd_sel;
  logic accept, last;
  assign key_ready = state != EXPAND;
  assign busy = state == EXPAND;
  assign keys_valid = state == READY;
  assign accept = key_valid & key_ready;
  assign last = cnt == 4'(AES_NR - 1);
  aes_key_round u_round (
    .rk_prev (rk[cnt]),
    .round   (cnt),
    .rk_next (rk_nx)
  );
  // next state: a load beats invalidate, invalidate beats completion
  always_comb begin
    state_nx = accept ? EXPAND : invalidate ? IDLE : (busy && last) ? READY : state;
  end
  // state, round counter and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= accept ? 4'd0 : busy ? cnt + 4'd1 : cnt;
      done <= busy && last && !invalidate;
    end
  end
  // key store is never cleared; keys_valid masks stale or partial contents
  always_ff @(posedge clk) begin
    if (accept) rk[0] <= key_in;
    else if (busy) rk[cnt + 4'd1] <= rk_nx;
  end
  assign rd_sel = (keys_valid && rk_rd_idx <= 4'(AES_NR)) ? rk[rk_rd_idx] : '0;
  if (REG_RD) begin : g_reg_rd
    logic [KEY_W-1:0] rd_q;
    // registered read, qualified by keys_valid at the sampling edge
    always_ff @(posedge clk) begin
      rd_q <= rst ? '0 : rd_sel;
    end
    assign rk_rd_data = rd_q;
  end else begin : g_comb_rd
    assign rk_rd_data = rd_sel;
  end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed table-driven bench for the AES-128 key schedule controller
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;
  localparam logic [127:0] FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ZERO = 128'h0;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, invalidate = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0] rk_rd_idx = '0;
  logic kr0, busy0, kv0, done0, kr1, busy1, kv1, done1;
  logic [127:0] rd0, rd1;
  int checks = 0, failures = 0;
  int n, low;
  logic seen;
  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [13];

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .REG_RD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr0), .key_in(key_in),
    .invalidate(invalidate), .busy(busy0), .keys_valid(kv0), .done(done0),
    .rk_rd_idx(rk_rd_idx), .rk_rd_data(rd0)
  );
  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .REG_RD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr1), .key_in(key_in),
    .invalidate(invalidate), .busy(busy1), .keys_valid(kv1), .done(done1),
    .rk_rd_idx(rk_rd_idx), .rk_rd_data(rd1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic load(input logic [127:0] k, input logic inv);
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    invalidate = inv;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    invalidate = 1'b0;
    chk1("load_busy", busy0, 1'b1);
    chk1("load_keys_valid", kv0, 1'b0);
    chk1("load_key_ready", kr0, 1'b0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
    end while (!done0 && cyc < 20);
  endtask

  task automatic finish_load(input string name);
    int c;
    wait_done(c);
    chk({name, "_latency"}, 128'(c), 128'(10));
    chk1({name, "_done1"}, done1, 1'b1);
    chk1({name, "_keys_valid"}, kv0, 1'b1);
    chk1({name, "_keys_valid1"}, kv1, 1'b1);
    chk1({name, "_busy"}, busy0, 1'b0);
    chk1({name, "_key_ready"}, kr0, 1'b1);
  endtask

  initial begin
    vt = '{
      '{4'd0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c},
      '{4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605},
      '{4'd2,  128'hf2c295f2_7a96b943_5935807a_7359f67f},
      '{4'd3,  128'h3d80477d_4716fe3e_1e237e44_6d7a883b},
      '{4'd4,  128'hef44a541_a8525b7f_b671253b_db0bad00},
      '{4'd5,  128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc},
      '{4'd6,  128'h6d88a37a_110b3efd_dbf98641_ca0093fd},
      '{4'd7,  128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f},
      '{4'd8,  128'head27321_b58dbad2_312bf560_7f8d292f},
      '{4'd9,  128'hac7766f3_19fadc21_28d12941_575c006e},
      '{4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6},
      '{4'd11, 128'h0},
      '{4'd15, 128'h0}
    };
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_key_ready", kr0, 1'b1);
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_keys_valid", kv0, 1'b0);
    chk1("rst_done", done0, 1'b0);
    chk("rst_rd0", rd0, ZERO);
    chk("rst_rd1", rd1, ZERO);
    rst = 1'b0;

    load(FIPS, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk1("midrst_key_ready", kr0, 1'b1);
    chk1("midrst_busy", busy0, 1'b0);
    chk1("midrst_keys_valid", kv0, 1'b0);
    chk1("midrst_done", done0, 1'b0);
    chk("midrst_rd1", rd1, ZERO);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      seen = seen | done0 | kv0;
    end
    chk1("midrst_no_done", seen, 1'b0);
    load(ZERO, 1'b0);
    finish_load("zero");
    rk_rd_idx = 4'd10;
    #1;
    chk("zero_idx10", rd0, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);

    load(FIPS, 1'b0);
    finish_load("fips");
    @(posedge clk);
    #1;
    chk1("done_one_cycle", done0, 1'b0);
    chk("fips_idx10", rd0, vt[10].exp);

    @(negedge clk);
    invalidate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    invalidate = 1'b0;
    chk1("inv_keys_valid", kv0, 1'b0);
    chk1("inv_key_ready", kr0, 1'b1);
    chk("inv_rd0", rd0, ZERO);

    @(negedge clk);
    key_in = FIPS;
    key_valid = 1'b1;
    rk_rd_idx = 4'd1;
    @(posedge clk);
    @(negedge clk);
    key_in = ZERO;
    n = 0;
    low = 0;
    while (!kv0 && n < 20) begin
      if (!kr0) low++;
      n++;
      @(negedge clk);
    end
    chk("hs_ready_low", 128'(low), 128'(10));
    chk1("hs_key_ready", kr0, 1'b1);
    chk("hs_first_idx1", rd0, vt[1].exp);
    rk_rd_idx = 4'd10;
    #1;
    chk("hs_first_idx10", rd0, vt[10].exp);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    chk1("hs_second_accept", busy0, 1'b1);
    chk1("hs_second_kv", kv0, 1'b0);
    finish_load("hs");
    chk("hs_second_idx10", rd0, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);
    rk_rd_idx = 4'd1;
    #1;
    chk("hs_second_idx1", rd0, 128'h62636363_62636363_62636363_62636363);

    load(FIPS, 1'b1);
    finish_load("reload");
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rk_rd_idx = vt[i].idx;
      #1;
      chk($sformatf("comb_idx%0d", vt[i].idx), rd0, vt[i].exp);
      if (i > 0) chk($sformatf("reg_lag_idx%0d", vt[i].idx), rd1, vt[i-1].exp);
      @(posedge clk);
      #1;
      chk($sformatf("reg_idx%0d", vt[i].idx), rd1, vt[i].exp);
    end

    load(FIPS, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    invalidate = 1'b1;
    @(posedge clk);
    #1;
    chk1("abort_busy", busy0, 1'b0);
    chk1("abort_keys_valid", kv0, 1'b0);
    chk1("abort_done", done0, 1'b0);
    @(negedge clk);
    invalidate = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      seen = seen | done0 | done1 | kv0;
    end
    chk1("abort_no_done", seen, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rk_rd_idx = 4'(i);
      #1;
      chk($sformatf("abort_rd0_idx%0d", i), rd0, ZERO);
      @(posedge clk);
      #1;
      chk($sformatf("abort_rd1_idx%0d", i), rd1, ZERO);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
